// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Pipeline write-back register with source select and retire counter.
//            Sub-word load extraction is built only when WB_LOAD_EXT_EN is defined.
// Revision : 1.0
// ============================================================================
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  mem_data_read_i,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  pcsrc_i,
  input  logic [XLEN-1:0]  offset_i,
  input  logic [1:0]       dmem_to_reg_i,
  input  logic [2:0]       funct3_i,
  input  logic [2:0]       addr_lsb_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             reg_write_i,
  output logic [XLEN-1:0]  write_data_reg_o,
  output logic [4:0]       rd_addr_o,
  output logic             reg_write_o,
  output logic             wb_valid_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  logic [XLEN-1:0]  mem_val;
  logic [XLEN-1:0]  sel_data;
  logic [XLEN-1:0]  wb_data;
  logic [4:0]       wb_rd;
  logic             wb_rw;
  logic             wb_valid;
  logic [CNT_W-1:0] retire_cnt;
  logic             advance;

`ifdef WB_LOAD_EXT_EN
  // Lane offsets are aligned down to the access size; XLEN=32 ignores addr bit 2.
  localparam logic [2:0] LANE_MASK = 3'(XLEN/8 - 1);

  logic [2:0]  byte_off;
  logic [2:0]  half_off;
  logic [2:0]  word_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;

  assign byte_off = addr_lsb_i & LANE_MASK;
  assign half_off = {byte_off[2:1], 1'b0};
  assign word_off = {byte_off[2], 2'b00};
  assign ld_byte  = 8'(mem_data_read_i >> {byte_off, 3'b000});
  assign ld_half  = 16'(mem_data_read_i >> {half_off, 3'b000});
  assign ld_word  = 32'(mem_data_read_i >> {word_off, 3'b000});

  always_comb begin
    mem_val = mem_data_read_i;
    case (funct3_i)
      3'b000:  mem_val = XLEN'($signed(ld_byte));
      3'b001:  mem_val = XLEN'($signed(ld_half));
      3'b010:  mem_val = XLEN'($signed(ld_word));
      3'b100:  mem_val = XLEN'(ld_byte);
      3'b101:  mem_val = XLEN'(ld_half);
      3'b110:  mem_val = XLEN'(ld_word);
      default: mem_val = mem_data_read_i;
    endcase
  end
`else
  logic unused_load_ctl;
  assign unused_load_ctl = ^{funct3_i, addr_lsb_i};
  assign mem_val         = mem_data_read_i;
`endif

  always_comb begin
    sel_data = mem_val;
    case (dmem_to_reg_i)
      2'b00:   sel_data = mem_val;
      2'b01:   sel_data = alu_result_i;
      2'b10:   sel_data = pcsrc_i;
      default: sel_data = offset_i;
    endcase
  end

  assign advance = ~stall_i & ~flush_i;

  // Flush only kills the valid bit; data fields keep their last captured value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_rw      <= 1'b0;
      wb_valid   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (flush_i) begin
        wb_valid <= 1'b0;
      end else if (!stall_i) begin
        wb_valid <= valid_i;
        if (valid_i) begin
          wb_data <= sel_data;
          wb_rd   <= rd_addr_i;
          wb_rw   <= reg_write_i;
        end
      end
      if (advance && wb_valid) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

  assign write_data_reg_o = wb_data;
  assign rd_addr_o        = wb_rd;
  assign reg_write_o      = wb_valid & wb_rw & (wb_rd != 5'd0);
  assign wb_valid_o       = wb_valid;
  assign retire_cnt_o     = retire_cnt;

endmodule
`default_nettype wire
